// File: rtl/ps_bigreg_collector_pkg.sv
// Shared memory-map layout for PS_BIGREG groups: state encoding,
// AXI response codes and the base/length of each wide-register group.
package ps_bigreg_collector_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    CLEAR   = 2'd2
  } bigreg_state_t;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t OKAY   = 2'b00;
  localparam axi_resp_t SLVERR = 2'b10;

  localparam int SEED_BASE_ID     = 1;
  localparam int SEED_SAMPLES     = 16;
  localparam int CHAN_MUX_BASE_ID = 32;
  localparam int SDC_BASE_ID      = 35;

  // The valid ID sits immediately after the last entry of a group.
  function automatic int valid_id(input int base_id, input int samples);
    return base_id + samples;
  endfunction

endpackage

// File: rtl/ps_bigreg_collector_fresh_clr_seq.sv
// Walks base, base+1, ... base+count emitting one registered freshbit-clear
// strobe per cycle; done is high during the final strobe.
module fresh_clr_seq #(
  parameter int ID_W  = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ID_W-1:0]  base,
  input  logic [CNT_W-1:0] count,
  output logic             clr_valid,
  output logic [ID_W-1:0]  clr_id,
  output logic             done
);

  logic             active_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ID_W-1:0]  id_q;

  // count is the offset of the last strobe, so count+1 strobes are issued.
  always_comb begin
    done = active_q && (cnt_q == count);
  end

  // Strobe sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      id_q     <= {ID_W{1'b0}};
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= {CNT_W{1'b0}};
      id_q     <= base;
    end else if (done) begin
      active_q <= 1'b0;
    end else if (active_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
      id_q  <= id_q + ID_W'(1);
    end else begin
      active_q <= active_q;
    end
  end

  assign clr_valid = active_q;
  assign clr_id    = id_q;

endmodule

// File: rtl/ps_bigreg_collector.sv
// Snoops PS writes to one PS_BIGREG group, assembles the wide register,
// hands it over valid/ready and then clears the group's freshbits.
module ps_bigreg_collector
  import ps_bigreg_collector_pkg::*;
#(
  parameter int BASE_ID = SEED_BASE_ID,
  parameter int SAMPLES = SEED_SAMPLES,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ID_W-1:0]             wr_id,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_resp_valid,
  output logic [1:0]                  wr_resp,
  output logic [SAMPLES*DATA_W-1:0]   bigreg_data,
  output logic                        bigreg_valid,
  input  logic                        bigreg_ready,
  output logic                        clr_valid,
  output logic [ID_W-1:0]             clr_id
);

  localparam int VALID_ID = valid_id(BASE_ID, SAMPLES);
  localparam int CNT_W    = $clog2(SAMPLES + 1);

  if (SAMPLES < 1 || DATA_W < 1 || ID_W < 1 || ID_W > 30 || VALID_ID >= (1 << ID_W)) begin : g_bad_cfg
    $error("ps_bigreg_collector: illegal SAMPLES/DATA_W/ID_W/BASE_ID configuration");
  end

  localparam logic [ID_W-1:0]  BASE_L  = ID_W'(BASE_ID);
  localparam logic [ID_W-1:0]  VALID_L = ID_W'(VALID_ID);
  localparam logic [CNT_W-1:0] LAST_L  = CNT_W'(SAMPLES);

  bigreg_state_t               state_q, state_d;
  logic [SAMPLES-1:0]          fresh_q, fresh_d;
  logic [SAMPLES*DATA_W-1:0]   shadow_q, shadow_d;
  logic [SAMPLES*DATA_W-1:0]   data_q, data_d;
  logic                        valid_q, valid_d;
  axi_resp_t                   resp_q, resp_d;
  logic                        resp_valid_q;
  logic                        hit_s, base_hit_s, start_s, done_s;
  logic [ID_W-1:0]             offset_s;

  // Range is checked before subtracting, so IDs below BASE_ID never wrap into the group.
  always_comb begin
    hit_s      = wr_en && (wr_id >= BASE_L) && (wr_id <= VALID_L);
    base_hit_s = hit_s && (wr_id != VALID_L);
    offset_s   = wr_id - BASE_L;
  end

  // Next-state, shadow assembly and response selection.
  always_comb begin
    state_d  = state_q;
    fresh_d  = fresh_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    resp_d   = OKAY;
    start_s  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (base_hit_s) begin
          for (int i = 0; i < SAMPLES; i++) begin
            if (offset_s == ID_W'(i)) begin
              shadow_d[i*DATA_W +: DATA_W] = wr_data;
              fresh_d[i]                   = 1'b1;
            end
          end
        end else if (hit_s) begin
          if (&fresh_q) begin
            data_d  = shadow_d;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            resp_d = SLVERR;
          end
        end else begin
          resp_d = OKAY;
        end
      end
      HOLD: begin
        resp_d = hit_s ? SLVERR : OKAY;
        if (valid_q && bigreg_ready) begin
          valid_d = 1'b0;
          start_s = 1'b1;
          state_d = CLEAR;
        end else begin
          valid_d = valid_q;
        end
      end
      CLEAR: begin
        resp_d = hit_s ? SLVERR : OKAY;
        if (done_s) begin
          fresh_d = {SAMPLES{1'b0}};
          state_d = COLLECT;
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      fresh_q      <= {SAMPLES{1'b0}};
      shadow_q     <= {(SAMPLES*DATA_W){1'b0}};
      data_q       <= {(SAMPLES*DATA_W){1'b0}};
      valid_q      <= 1'b0;
      resp_q       <= OKAY;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fresh_q      <= fresh_d;
      shadow_q     <= shadow_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      resp_q       <= resp_d;
      resp_valid_q <= hit_s;
    end
  end

  fresh_clr_seq #(
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .base      (BASE_L),
    .count     (LAST_L),
    .clr_valid (clr_valid),
    .clr_id    (clr_id),
    .done      (done_s)
  );

  assign wr_resp_valid = resp_valid_q;
  assign wr_resp       = resp_q;
  assign bigreg_data   = data_q;
  assign bigreg_valid  = valid_q;

endmodule

// File: tb/tb_ps_bigreg_collector.sv
// Scoreboard bench: stimulus queues expected responses, wide-register values
// and clear IDs; a negedge monitor pops and compares whatever the DUT presents.
module tb_ps_bigreg_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [7:0]   wr_id;
  logic [15:0]  wr_data;
  logic         wr_resp_valid;
  logic [1:0]   wr_resp;
  logic [255:0] bigreg_data;
  logic         bigreg_valid;
  logic         bigreg_ready;
  logic         clr_valid;
  logic [7:0]   clr_id;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]   exp_resp_q[$];
  logic [255:0] exp_data_q[$];
  logic [7:0]   exp_clr_q[$];

  always #5 clk = ~clk;

  ps_bigreg_collector dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_id         (wr_id),
    .wr_data       (wr_data),
    .wr_resp_valid (wr_resp_valid),
    .wr_resp       (wr_resp),
    .bigreg_data   (bigreg_data),
    .bigreg_valid  (bigreg_valid),
    .bigreg_ready  (bigreg_ready),
    .clr_valid     (clr_valid),
    .clr_id        (clr_id)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] id, input logic [15:0] d, input bit hit, input logic [1:0] er);
    wr_en   = 1'b1;
    wr_id   = id;
    wr_data = d;
    if (hit) exp_resp_q.push_back(er);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic handshake(input bit with_wr);
    bigreg_ready = 1'b1;
    if (with_wr) begin
      wr_en   = 1'b1;
      wr_id   = 8'd5;
      wr_data = 16'hBEEF;
      exp_resp_q.push_back(ERR);
    end
    for (int k = 1; k <= 17; k++) exp_clr_q.push_back(8'(k));
    @(posedge clk); #1;
    bigreg_ready = 1'b0;
    wr_en        = 1'b0;
  endtask

  // Monitor: compares every response, register handover and clear strobe.
  initial begin
    logic         prev_valid;
    logic         clr_active;
    logic [255:0] held;
    prev_valid = 1'b0;
    clr_active = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        clr_active = 1'b0;
      end else begin
        if (wr_resp_valid) begin
          if (exp_resp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_resp: got %0h expected none", wr_resp);
          end else begin
            check("wr_resp", 256'(wr_resp), 256'(exp_resp_q.pop_front()));
          end
        end
        if (bigreg_valid && !prev_valid) begin
          if (exp_data_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_valid: got %0h expected none", bigreg_data);
          end else begin
            check("bigreg_data", bigreg_data, exp_data_q.pop_front());
          end
        end else if (bigreg_valid) begin
          check("data_stable", bigreg_data, held);
        end
        held       = bigreg_data;
        prev_valid = bigreg_valid;
        if (clr_valid) begin
          if (exp_clr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_clr: got %0d expected none", clr_id);
          end else begin
            check("clr_id", 256'(clr_id), 256'(exp_clr_q.pop_front()));
          end
          clr_active = (exp_clr_q.size() != 0);
        end else if (clr_active) begin
          n_vec++; n_err++;
          $display("FAIL clr_gap: got clr_valid 0 expected 1");
          clr_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp1, exp6, exp5;
    bit           found;
    rst = 1'b1; wr_en = 1'b0; wr_id = '0; wr_data = '0; bigreg_ready = 1'b0;
    #1;
    check("rst_bigreg_valid", 256'(bigreg_valid), 256'd0);
    check("rst_clr_valid", 256'(clr_valid), 256'd0);
    check("rst_clr_id", 256'(clr_id), 256'd0);
    check("rst_resp_valid", 256'(wr_resp_valid), 256'd0);
    check("rst_resp", 256'(wr_resp), 256'd0);
    check("rst_data", bigreg_data, 256'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Full load, out-of-range writes, then the valid ID.
    exp1 = '0;
    for (int i = 1; i <= 16; i++) begin
      exp1[(i-1)*16 +: 16] = 16'(i * 257);
      wr(8'(i), 16'(i * 257), 1'b1, OK);
    end
    wr(8'd0, 16'hFFFF, 1'b0, OK);
    @(negedge clk); check("id0_no_resp", 256'(wr_resp_valid), 256'd0);
    wr(8'd18, 16'hEEEE, 1'b0, OK);
    @(negedge clk); check("id18_no_resp", 256'(wr_resp_valid), 256'd0);
    check("pre_valid_low", 256'(bigreg_valid), 256'd0);
    exp_data_q.push_back(exp1);
    wr(8'd17, 16'h0000, 1'b1, OK);
    @(negedge clk); check("valid_latency", 256'(bigreg_valid), 256'd1);

    // Hold with ready low, reject a write, then handshake with a colliding write.
    repeat (20) begin @(posedge clk); #1; end
    wr(8'd5, 16'hDEAD, 1'b1, ERR);
    @(negedge clk); check("hold_data", bigreg_data, exp1);
    @(posedge clk); #1;
    handshake(1'b1);
    @(negedge clk); check("valid_dropped", 256'(bigreg_valid), 256'd0);
    @(posedge clk); #1;
    repeat (15) begin @(posedge clk); #1; end
    wr(8'd3, 16'h7777, 1'b1, ERR);
    wr(8'd3, 16'h3333, 1'b1, OK);

    // Partial load rejected, double write to ID 3, then complete and fire.
    exp6 = exp1;
    exp6[2*16 +: 16] = 16'h5555;
    for (int i = 1; i <= 15; i++) begin
      if (i == 3) begin
        wr(8'd3, 16'hAAAA, 1'b1, OK);
        wr(8'd3, 16'h5555, 1'b1, OK);
      end else begin
        wr(8'(i), 16'(i * 257), 1'b1, OK);
      end
    end
    wr(8'd17, 16'h0000, 1'b1, ERR);
    @(negedge clk); check("partial_no_valid", 256'(bigreg_valid), 256'd0);
    wr(8'd16, 16'h1010, 1'b1, OK);
    exp_data_q.push_back(exp6);
    wr(8'd17, 16'h0000, 1'b1, OK);
    @(negedge clk); check("valid_after_fill", 256'(bigreg_valid), 256'd1);
    @(posedge clk); #1;

    // Reset in the middle of the clear walk.
    handshake(1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (clr_valid && clr_id == 8'd9) found = 1'b1;
    end
    check("clr9_reached", 256'(found), 256'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_clr_valid", 256'(clr_valid), 256'd0);
    check("rst_mid_bigreg_valid", 256'(bigreg_valid), 256'd0);
    check("rst_mid_data", bigreg_data, 256'd0);
    exp_clr_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr(8'd17, 16'h0000, 1'b1, ERR);
    @(negedge clk); check("mask_cleared", 256'(bigreg_valid), 256'd0);
    exp5 = '0;
    for (int i = 1; i <= 16; i++) begin
      exp5[(i-1)*16 +: 16] = 16'(16'h1000 + i);
      wr(8'(i), 16'(16'h1000 + i), 1'b1, OK);
    end
    exp_data_q.push_back(exp5);
    wr(8'd17, 16'h0000, 1'b1, OK);
    @(negedge clk); check("reload_valid", 256'(bigreg_valid), 256'd1);
    @(posedge clk); #1;
    handshake(1'b0);
    repeat (25) begin @(posedge clk); #1; end

    check("resp_queue_drained", 256'(exp_resp_q.size()), 256'd0);
    check("data_queue_drained", 256'(exp_data_q.size()), 256'd0);
    check("clr_queue_drained", 256'(exp_clr_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps_bigreg_collector.md
Name: ps_bigreg_collector

Overview:
Sits directly downstream of the AXI memory map. It snoops processor writes to one PS_BIGREG group (base IDs plus a valid ID) and assembles the 16-bit entries into one wide register. The wide register goes to RTL consumers (seed generator, channel mux, sample discriminator) over a valid/ready handshake. Once the consumer has taken the value, the block clears the freshbits of every address in the group, one address per cycle, so the PS can reload it.

Parameters:
BASE_ID, 1, memory-map index of entry 0 (seed group; 32 for channel mux, 35 for SDC)
SAMPLES, 16, number of entries in the group; VALID_ID = BASE_ID + SAMPLES
DATA_W, 16, width of one entry (WD_DATA_WIDTH)
ID_W, 8, index width ($clog2(MEM_SIZE))

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  PS write to the memory map accepted this cycle
wr_id  in  ID_W  memory-map index of that write
wr_data  in  DATA_W  low DATA_W bits of the write data
wr_resp_valid  out  1  one-cycle pulse: response for a write that hit this group
wr_resp  out  2  OKAY (2'b00) or SLVERR (2'b10)
bigreg_data  out  SAMPLES*DATA_W  assembled register; entry i sits at bits [i*DATA_W +: DATA_W]
bigreg_valid  out  1  assembled register is valid
bigreg_ready  in  1  consumer accepts the register
clr_valid  out  1  freshbit clear strobe to the memory map
clr_id  out  ID_W  index whose freshbit is cleared

Behaviour:
- Reset (asynchronous, takes effect immediately): state=COLLECT, fresh mask=0, shadow=0, bigreg_data=0, bigreg_valid=0, clr_valid=0, clr_id=0, wr_resp_valid=0, wr_resp=OKAY.
- A "hit" is wr_en with BASE_ID <= wr_id <= VALID_ID. Other IDs are ignored and produce no response.
- Every hit produces wr_resp_valid exactly one cycle after wr_en, with wr_resp registered.
- COLLECT:
  - Base hit (wr_id < VALID_ID): shadow[wr_id-BASE_ID] <= wr_data; set fresh bit; OKAY. Rewriting an entry overwrites it; its fresh bit stays 1.
  - Valid hit with fresh mask all ones: bigreg_data <= shadow, with the same-cycle write merged in if any; bigreg_valid <= 1; go to HOLD; OKAY.
  - Valid hit with fresh mask not all ones: SLVERR; shadow and mask unchanged; stay in COLLECT.
- HOLD:
  - bigreg_data is stable while bigreg_valid=1.
  - bigreg_valid & bigreg_ready: bigreg_valid <= 0 on the next edge; go to CLEAR; counter=0.
  - Any hit in HOLD or CLEAR: SLVERR; data is dropped.
- CLEAR:
  - Lasts SAMPLES+1 cycles. Each cycle clr_valid=1 and clr_id=BASE_ID+counter; counter increments.
  - After the strobe with clr_id=VALID_ID: fresh mask <= 0, go to COLLECT. Shadow is kept (not zeroed).
  - clr_valid and clr_id are registered.
- Latencies:
  - Valid write to bigreg_valid high: 1 cycle.
  - Handshake to first clr_valid: 1 cycle.
  - Handshake to COLLECT: SAMPLES+2 cycles.
- Simultaneous wr_en and bigreg_ready in HOLD: the handshake completes and the write gets SLVERR.
- Reset mid-CLEAR: the clear sequence is abandoned. The memory map's own reset clears its freshbits, so nothing is left stale.
- Arithmetic: offset = wr_id - BASE_ID on ID_W bits, compared before the subtraction so IDs below BASE_ID never alias. counter is $clog2(SAMPLES+1) bits.
- Zero-width or SAMPLES=0 configurations are illegal; an elaboration assertion rejects them.

Decomposition:
- mem_layout_pkg gains:
  - typedef enum {COLLECT, HOLD, CLEAR} bigreg_state_t
  - typedef logic[1:0] axi_resp_t
  - the existing OKAY/SLVERR codes
  - BASE_ID/SAMPLES instantiation values derived from the existing ID macros
- One sub-module, fresh_clr_seq: takes start, base and count; emits clr_valid/clr_id and done. It is reusable for the CHAN_MUX and SDC groups.

Test Plan:
1. Write IDs 1..16 with data 16'h0101*i, then ID 17 -> bigreg_valid high 1 cycle later; entry i = 16'h0101*i; every wr_resp OKAY.
2. Write IDs 1..15 only, then ID 17 -> wr_resp SLVERR; bigreg_valid stays 0; writing ID 16 then ID 17 -> valid asserts.
3. Hold bigreg_ready low 20 cycles after valid; write ID 5 -> SLVERR; bigreg_data unchanged. Raise ready -> clr_id 1..17 on 17 consecutive cycles, then COLLECT.
4. Write ID 0 and ID 18 with wr_en -> no wr_resp_valid; mask unchanged.
5. Assert rst during CLEAR at clr_id=9 -> clr_valid and bigreg_valid drop immediately; mask=0. A fresh 1..17 load works.
6. Write ID 3 twice (16'hAAAA then 16'h5555) before valid -> entry 2 = 16'h5555.
